// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: shared select codes, shadow-stage records and match helpers
package hazard_fwd_ctrl_pkg;
  localparam logic [2:0] FWD_REG = 3'd0;
  localparam logic [2:0] FWD_W   = 3'd1;
  localparam logic [2:0] FWD_M   = 3'd2;
  localparam logic [2:0] FWD_PC8 = 3'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // E-stage shadow: everything decode knows about the instruction
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md_start;
    logic       md_div;
  } stage_t;

  // M-stage shadow: only the fields that M forwarding and stalling consume
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rt;
  } late_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hit(input logic [4:0] dst, input logic [4:0] s);
    return (s != 5'd0) && (dst == s);
  endfunction
endpackage

// File: rtl/hazard_fwd_ctrl_md_busy_ctr.sv
// hazard_fwd_ctrl_md_busy_ctr: multiply/divide busy countdown, loaded as the op leaves E
module hazard_fwd_ctrl_md_busy_ctr #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);
  localparam int W = $clog2((DIV_CYC > MULT_CYC ? DIV_CYC : MULT_CYC) + 1);
  logic [W-1:0] cnt;
  // load on start, otherwise count down and hold at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (start) cnt <= div ? W'(DIV_CYC) : W'(MULT_CYC);
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign busy = cnt != '0;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: shadow E/M/W pipeline driving forwarding selects and the D-stage stall
import hazard_fwd_ctrl_pkg::*;

module hazard_fwd_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [2:0] frsd,
  output logic [2:0] frtd,
  output logic [1:0] frse,
  output logic [1:0] frte,
  output logic       frtm,
  output logic       md_busy
);
  stage_t e;
  late_t m;
  logic [4:0] w_dst;

  function automatic logic raw(input logic [4:0] s, input logic [1:0] tuse);
    return tuse != TUSE_NONE &&
           ((hit(e.dst, s) && tuse < e.tnew) || (hit(m.dst, s) && tuse < m.tnew));
  endfunction

  // the youngest matching stage owns the value even when it is not ready yet
  function automatic logic [2:0] fwd_d(input logic [4:0] s);
    return hit(e.dst, s) ? (e.tnew == 2'd0 ? FWD_PC8 : FWD_REG) :
           hit(m.dst, s) ? (m.tnew == 2'd0 ? FWD_M : FWD_REG) :
           hit(w_dst, s) ? FWD_W : FWD_REG;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] s);
    return (hit(m.dst, s) && m.tnew == 2'd0) ? FWD_M[1:0] :
           hit(w_dst, s) ? FWD_W[1:0] : FWD_REG[1:0];
  endfunction

  // advance the shadow pipe; a stall turns the E entry into a bubble
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e     <= '0;
      m     <= '0;
      w_dst <= '0;
    end else begin
      e     <= stall ? '0 : '{dst: d_dst, tnew: d_tnew, rs: d_rs, rt: d_rt,
                              md_start: d_md_start, md_div: d_md_div};
      m     <= '{dst: e.dst, tnew: tnew_dec(e.tnew), rt: e.rt};
      w_dst <= m.dst;
    end

  // hazard detection and forwarding selects
  always_comb begin
    stall = raw(d_rs, d_tuse_rs) || raw(d_rt, d_tuse_rt) || (d_md_use && (md_busy || e.md_start));
    frsd  = fwd_d(d_rs);
    frtd  = fwd_d(d_rt);
    frse  = fwd_e(e.rs);
    frte  = fwd_e(e.rt);
    frtm  = hit(w_dst, m.rt);
  end

  hazard_fwd_ctrl_md_busy_ctr #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) md_busy_ctr (
    .clk  (clk),
    .reset(reset),
    .start(e.md_start),
    .div  (e.md_div),
    .busy (md_busy)
  );
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scoreboarded instruction sequences against the hazard/forwarding controller
module tb_hazard_fwd_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, frtm, md_busy;
  logic [2:0] frsd, frtd;
  logic [1:0] frse, frte;
  int         total = 0;
  int         passed = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic [2:0] frsd, frtd;
    logic [1:0] frse, frte;
    logic       frtm, md_busy;
  } exp_t;
  exp_t q[$];
  exp_t cur;

  hazard_fwd_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start),
    .d_md_div(d_md_div), .d_md_use(d_md_use), .stall(stall), .frsd(frsd), .frtd(frtd),
    .frse(frse), .frte(frte), .frtm(frtm), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic ins(input logic [4:0] rs, rt, input logic [1:0] tur, tut,
                     input logic [4:0] dst, input logic [1:0] tnew, input logic ms, mdv, mu);
    d_rs = rs; d_rt = rt; d_tuse_rs = tur; d_tuse_rt = tut;
    d_dst = dst; d_tnew = tnew; d_md_start = ms; d_md_div = mdv; d_md_use = mu;
  endtask

  task automatic nop;
    ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input string tag, input logic st, input logic [2:0] fsd, ftd,
                          input logic [1:0] fse, fte, input logic ftm, bz);
    q.push_back('{tag, st, fsd, ftd, fse, fte, ftm, bz});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, int'(stall), 0);
    chk({tag, ".frsd"}, int'(frsd), 0);
    chk({tag, ".frtd"}, int'(frtd), 0);
    chk({tag, ".frse"}, int'(frse), 0);
    chk({tag, ".frte"}, int'(frte), 0);
    chk({tag, ".frtm"}, int'(frtm), 0);
    chk({tag, ".busy"}, int'(md_busy), 0);
  endtask

  // compare the outputs of the current cycle against the oldest queued expectation
  always @(negedge clk)
    if (q.size() != 0) begin
      cur = q.pop_front();
      chk({cur.tag, ".stall"}, int'(stall), int'(cur.stall));
      chk({cur.tag, ".frsd"}, int'(frsd), int'(cur.frsd));
      chk({cur.tag, ".frtd"}, int'(frtd), int'(cur.frtd));
      chk({cur.tag, ".frse"}, int'(frse), int'(cur.frse));
      chk({cur.tag, ".frte"}, int'(frte), int'(cur.frte));
      chk({cur.tag, ".frtm"}, int'(frtm), int'(cur.frtm));
      chk({cur.tag, ".busy"}, int'(md_busy), int'(cur.md_busy));
    end

  initial begin
    nop();
    #2 chk_zero("reset0");
    @(posedge clk);
    #1 reset = 1'b1;
    // addu $3 then beq $3,$3: one stall, then forward from M
    tick; ins(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0); push_exp("a0", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd3, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0); push_exp("a1", 1, 0, 0, 0, 0, 0, 0);
    tick; push_exp("a2", 0, 2, 2, 0, 0, 0, 0);
    tick; nop(); push_exp("a3", 0, 0, 0, 1, 1, 0, 0);
    // lw $5 then addu reading $5: one stall, M not ready must not fall through, then W to E
    tick; ins(5'd4, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0); push_exp("b0", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd5, 5'd7, 2'd1, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0); push_exp("b1", 1, 0, 0, 0, 0, 0, 0);
    tick; push_exp("b2", 0, 0, 0, 0, 0, 0, 0);
    tick; nop(); push_exp("b3", 0, 0, 0, 1, 0, 0, 0);
    // jal $31 in E, jr $31 in D: PC+8 forward, then M to E
    tick; ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0); push_exp("c0", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0); push_exp("c1", 0, 3, 0, 0, 0, 0, 0);
    tick; nop(); push_exp("c2", 0, 0, 0, 2, 0, 0, 0);
    // lw $8 then sw of $8: store data forwarded from W into M
    tick; ins(5'd1, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0); push_exp("d0", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd2, 5'd8, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0); push_exp("d1", 0, 0, 0, 0, 0, 0, 0);
    tick; nop(); push_exp("d2", 0, 0, 0, 0, 0, 0, 0);
    tick; push_exp("d3", 0, 0, 0, 0, 0, 1, 0);
    // writes to $0 in flight and reads of $0: nothing forwards or stalls
    tick; ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0); push_exp("e0", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0); push_exp("e1", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0); push_exp("e2", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0); push_exp("e3", 0, 0, 0, 0, 0, 0, 0);
    // div then mflo: stalled through the E cycle and 10 busy cycles
    tick; ins(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1); push_exp("f_div", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b1); push_exp("f_div_e", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick; push_exp("f_div_busy", 1, 0, 0, 0, 0, 0, 1);
    end
    tick; push_exp("f_div_done", 0, 0, 0, 0, 0, 0, 0);
    // mult then mfhi: 5 busy cycles
    tick; ins(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1); push_exp("f_mul", 0, 0, 0, 0, 0, 0, 0);
    tick; ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1); push_exp("f_mul_e", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick; push_exp("f_mul_busy", 1, 0, 0, 0, 0, 0, 1);
    end
    tick; push_exp("f_mul_done", 0, 0, 0, 0, 0, 0, 0);
    // reset asserted mid-divide with the counter at 7
    tick; ins(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1); push_exp("g0", 0, 0, 0, 0, 0, 0, 0);
    tick; nop(); push_exp("g1", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick; push_exp("g_busy", 0, 0, 0, 0, 0, 0, 1);
    end
    tick; ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b1);
    #1 chk("g_pre.stall", int'(stall), 1);
    chk("g_pre.busy", int'(md_busy), 1);
    reset = 1'b0;
    #1 chk_zero("g_async");
    tick; chk_zero("g_held");
    reset = 1'b1;
    push_exp("g_release", 0, 0, 0, 0, 0, 0, 0);
    tick; nop(); push_exp("g_empty", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 if (q.size() != 0) chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
